// File: rtl/pipe_ctrl_pkg.sv
// Shared types and stall/flush encodings for the pipeline stall/flush sequencer.
// Each encoding is built from stage bit indices so the bit order lives in one place.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        EX_WAIT  = 2'd2
    } ctrl_state_e;

    localparam int PC_B    = 0;
    localparam int IFID_B  = 1;
    localparam int IDEX_B  = 2;
    localparam int EXMEM_B = 3;
    localparam int MEMWB_B = 4;

    function automatic logic [4:0] stage_mask(input logic pc, input logic ifid,
                                              input logic idex, input logic exmem,
                                              input logic memwb);
        logic [4:0] m;
        m          = '0;
        m[PC_B]    = pc;
        m[IFID_B]  = ifid;
        m[IDEX_B]  = idex;
        m[EXMEM_B] = exmem;
        m[MEMWB_B] = memwb;
        return m;
    endfunction

    localparam logic [4:0] STALL_MEM = stage_mask(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    localparam logic [4:0] FLUSH_MEM = stage_mask(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    localparam logic [4:0] STALL_EX  = stage_mask(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    localparam logic [4:0] FLUSH_EX  = stage_mask(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    localparam logic [4:0] FLUSH_EXC = stage_mask(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    localparam logic [4:0] FLUSH_BR  = stage_mask(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    localparam logic [4:0] STALL_LU  = stage_mask(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    localparam logic [4:0] FLUSH_LU  = stage_mask(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    localparam logic [4:0] FLUSH_RST = stage_mask(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use compare: the load in EX writes a register that the instruction in ID reads.
// x0 is never a real dependency.
module hazard_detect (
    input  logic       i_rs1_en,
    input  logic [4:0] i_rs1_addr,
    input  logic       i_rs2_en,
    input  logic [4:0] i_rs2_addr,
    input  logic       i_ex_rw_en,
    input  logic [4:0] i_ex_rw_addr,
    input  logic       i_ex_is_load,
    output logic       o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = i_rs1_en && (i_rs1_addr == i_ex_rw_addr);
    assign w_rs2_hit  = i_rs2_en && (i_rs2_addr == i_ex_rw_addr);
    assign o_load_use = i_ex_is_load && i_ex_rw_en && (i_ex_rw_addr != 5'd0)
                        && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage core: prioritises hazards, tracks
// LSU wait time with a timeout pulse, and counts PC-stall cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_rs1_en,
    input  logic [4:0]       id_rs1_addr,
    input  logic             id_rs2_en,
    input  logic [4:0]       id_rs2_addr,
    input  logic             ex_rw_en,
    input  logic [4:0]       ex_rw_addr,
    input  logic             ex_is_load,
    input  logic             ex_busy,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             branch_taken,
    input  logic             exc_valid,
    output logic [4:0]       stall,
    output logic [4:0]       flush,
    output logic [1:0]       ctrl_state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    ctrl_state_e       r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_load_use;
    logic              w_mem_wait;
    logic [4:0]        w_stall;
    logic [4:0]        w_flush;
    logic [4:0]        w_stall_eff;
    ctrl_state_e       w_next;

    hazard_detect u_hazard_detect (
        .i_rs1_en     (id_rs1_en),
        .i_rs1_addr   (id_rs1_addr),
        .i_rs2_en     (id_rs2_en),
        .i_rs2_addr   (id_rs2_addr),
        .i_ex_rw_en   (ex_rw_en),
        .i_ex_rw_addr (ex_rw_addr),
        .i_ex_is_load (ex_is_load),
        .o_load_use   (w_load_use)
    );

    // A taken branch under an active wait is dropped here; EX is held, so it returns later.
    always_comb begin
        w_stall    = '0;
        w_flush    = '0;
        w_next     = RUN;
        w_mem_wait = 1'b0;
        if (exc_valid) begin
            w_flush = FLUSH_EXC;
        end else if (mem_req && !mem_ready) begin
            w_stall    = STALL_MEM;
            w_flush    = FLUSH_MEM;
            w_next     = MEM_WAIT;
            w_mem_wait = 1'b1;
        end else if (ex_busy) begin
            w_stall = STALL_EX;
            w_flush = FLUSH_EX;
            w_next  = EX_WAIT;
        end else if (branch_taken) begin
            w_flush = FLUSH_BR;
        end else if (w_load_use) begin
            w_stall = STALL_LU;
            w_flush = FLUSH_LU;
        end
    end

    assign w_stall_eff = rst ? (w_stall & ~w_flush) : 5'b00000;
    assign stall       = w_stall_eff;
    assign flush       = rst ? w_flush : FLUSH_RST;
    assign ctrl_state  = r_state;
    assign mem_timeout = r_timeout;
    assign stall_cnt   = r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state   <= w_next;
            r_timeout <= w_mem_wait && (r_wait_cnt == WAIT_LAST);
            // The wait counter wraps on timeout and the wait simply continues.
            if (w_mem_wait && (r_wait_cnt != WAIT_LAST)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_stall_eff[PC_B] && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and random stimulus for pipe_ctrl; per-cycle expectations go through a queue.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        id_rs1_en;
    logic [4:0]  id_rs1_addr;
    logic        id_rs2_en;
    logic [4:0]  id_rs2_addr;
    logic        ex_rw_en;
    logic [4:0]  ex_rw_addr;
    logic        ex_is_load;
    logic        ex_busy;
    logic        mem_req;
    logic        mem_ready;
    logic        branch_taken;
    logic        exc_valid;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic [1:0]  ctrl_state;
    logic        mem_timeout;
    logic [31:0] stall_cnt;

    logic [12:0] exp_q[$];
    logic [31:0] exp_cnt;
    int          n_checks;
    int          n_fail;

    pipe_ctrl #(.MEM_TIMEOUT(8), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1_en    (id_rs1_en),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs2_en    (id_rs2_en),
        .id_rs2_addr  (id_rs2_addr),
        .ex_rw_en     (ex_rw_en),
        .ex_rw_addr   (ex_rw_addr),
        .ex_is_load   (ex_is_load),
        .ex_busy      (ex_busy),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .exc_valid    (exc_valid),
        .stall        (stall),
        .flush        (flush),
        .ctrl_state   (ctrl_state),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        id_rs1_en    = 1'b0;
        id_rs1_addr  = 5'd0;
        id_rs2_en    = 1'b0;
        id_rs2_addr  = 5'd0;
        ex_rw_en     = 1'b0;
        ex_rw_addr   = 5'd0;
        ex_is_load   = 1'b0;
        ex_busy      = 1'b0;
        mem_req      = 1'b0;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        exc_valid    = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_is_load  = 1'b1;
        ex_rw_en    = 1'b1;
        ex_rw_addr  = rd;
        id_rs2_en   = 1'b1;
        id_rs2_addr = rd;
    endtask

    // Queue the expectation for the cycle being driven, then compare mid-cycle.
    task automatic step(input logic [4:0] es, input logic [4:0] ef,
                        input logic [1:0] est, input logic eto);
        logic [12:0] e;
        exp_q.push_back({es, ef, est, eto});
        if (es[0]) exp_cnt++;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("stall", 32'(stall), 32'(e[12:8]));
            check("flush", 32'(flush), 32'(e[7:3]));
            check("ctrl_state", 32'(ctrl_state), 32'(e[2:1]));
            check("mem_timeout", 32'(mem_timeout), 32'(e[0]));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic lu;
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 32'd0;
        rst      = 1'b0;
        clear_inputs();
        #2;
        check("rst_stall", 32'(stall), 32'h00);
        check("rst_flush", 32'(flush), 32'h1e);
        check("rst_state", 32'(ctrl_state), 32'd0);
        check("rst_timeout", 32'(mem_timeout), 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // load-use: one bubble, then the same ID instruction proceeds
        set_load_use(5'd5);
        step(5'b00011, 5'b00100, 2'd0, 1'b0);
        ex_is_load = 1'b0;
        ex_rw_en   = 1'b0;
        step(5'b00000, 5'b00000, 2'd0, 1'b0);
        check("cnt_after_lu", stall_cnt, exp_cnt);
        check("cnt_lu_is_1", stall_cnt, 32'd1);
        clear_inputs();

        // MEM wait: three cycles low, then ready
        mem_req = 1'b1;
        step(5'b01111, 5'b10000, 2'd0, 1'b0);
        step(5'b01111, 5'b10000, 2'd1, 1'b0);
        step(5'b01111, 5'b10000, 2'd1, 1'b0);
        mem_ready = 1'b1;
        step(5'b00000, 5'b00000, 2'd1, 1'b0);
        clear_inputs();
        step(5'b00000, 5'b00000, 2'd0, 1'b0);
        check("cnt_after_mem", stall_cnt, 32'd4);

        // EX busy with a branch pending: branch only after busy drops
        ex_busy      = 1'b1;
        branch_taken = 1'b1;
        step(5'b00111, 5'b01000, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) step(5'b00111, 5'b01000, 2'd2, 1'b0);
        ex_busy = 1'b0;
        step(5'b00000, 5'b00110, 2'd2, 1'b0);
        branch_taken = 1'b0;
        step(5'b00000, 5'b00000, 2'd0, 1'b0);

        // EX_WAIT -> MEM_WAIT -> EX_WAIT -> RUN
        ex_busy = 1'b1;
        step(5'b00111, 5'b01000, 2'd0, 1'b0);
        mem_req = 1'b1;
        step(5'b01111, 5'b10000, 2'd2, 1'b0);
        step(5'b01111, 5'b10000, 2'd1, 1'b0);
        mem_ready = 1'b1;
        step(5'b00111, 5'b01000, 2'd1, 1'b0);
        clear_inputs();
        step(5'b00000, 5'b00000, 2'd2, 1'b0);
        step(5'b00000, 5'b00000, 2'd0, 1'b0);

        // exception during MEM wait with load-use also present
        mem_req = 1'b1;
        step(5'b01111, 5'b10000, 2'd0, 1'b0);
        step(5'b01111, 5'b10000, 2'd1, 1'b0);
        exc_valid = 1'b1;
        set_load_use(5'd7);
        step(5'b00000, 5'b01110, 2'd1, 1'b0);
        exc_valid = 1'b0;
        mem_req   = 1'b0;
        step(5'b00011, 5'b00100, 2'd0, 1'b0);

        // load-use together with a taken branch: branch wins
        branch_taken = 1'b1;
        step(5'b00000, 5'b00110, 2'd0, 1'b0);
        clear_inputs();
        step(5'b00000, 5'b00000, 2'd0, 1'b0);
        check("cnt_mid", stall_cnt, exp_cnt);

        // timeout: pulse follows wait cycles 8 and 16
        mem_req = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step(5'b01111, 5'b10000, (k == 1) ? 2'd0 : 2'd1, (k == 9) || (k == 17));
        end
        mem_ready = 1'b1;
        step(5'b00000, 5'b00000, 2'd1, 1'b0);
        clear_inputs();
        step(5'b00000, 5'b00000, 2'd0, 1'b0);
        check("cnt_after_to", stall_cnt, exp_cnt);

        // random load-use patterns over a small register window
        for (int i = 0; i < 24; i++) begin
            id_rs1_en   = 1'($urandom_range(0, 1));
            id_rs1_addr = 5'($urandom_range(0, 3));
            id_rs2_en   = 1'($urandom_range(0, 1));
            id_rs2_addr = 5'($urandom_range(0, 3));
            ex_rw_en    = 1'($urandom_range(0, 1));
            ex_rw_addr  = 5'($urandom_range(0, 3));
            ex_is_load  = 1'($urandom_range(0, 1));
            lu = ex_is_load && ex_rw_en && (ex_rw_addr != 5'd0) &&
                 ((id_rs1_en && (id_rs1_addr == ex_rw_addr)) ||
                  (id_rs2_en && (id_rs2_addr == ex_rw_addr)));
            step(lu ? 5'b00011 : 5'b00000, lu ? 5'b00100 : 5'b00000, 2'd0, 1'b0);
        end
        clear_inputs();
        step(5'b00000, 5'b00000, 2'd0, 1'b0);
        check("cnt_after_rand", stall_cnt, exp_cnt);

        // asynchronous reset in the middle of a MEM wait
        mem_req = 1'b1;
        step(5'b01111, 5'b10000, 2'd0, 1'b0);
        for (int k = 2; k <= 5; k++) step(5'b01111, 5'b10000, 2'd1, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        check("midrst_stall", 32'(stall), 32'h00);
        check("midrst_flush", 32'(flush), 32'h1e);
        check("midrst_state", 32'(ctrl_state), 32'd0);
        check("midrst_cnt", stall_cnt, 32'd0);
        clear_inputs();
        exp_cnt = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("post_rst_cnt", stall_cnt, 32'd0);
        check("post_rst_state", 32'(ctrl_state), 32'd0);
        step(5'b00000, 5'b00000, 2'd0, 1'b0);

        // wait counter restarted from zero: first pulse after a full 8 cycles
        mem_req = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step(5'b01111, 5'b10000, (k == 1) ? 2'd0 : 2'd1, k == 9);
        end
        clear_inputs();
        step(5'b00000, 5'b00000, 2'd1, 1'b0);
        check("final_cnt", stall_cnt, 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
